muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Per-thread multi-cycle integer multiply/divide unit sitting directly downstream of the thread register file. It consumes the `rs`/`rt` operand values and returns a result that the core's writeback path steers onto the register file's `rd` write input. The unit runs iterative shift-add multiplication and restoring division over WIDTH cycles. It uses a start/ack handshake so the core scheduler can hold the thread in its wait state until `result_valid` is asserted.

## Interface
- `WIDTH`, default 8: operand and result width in bits; matches the register file word.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; returns the block to IDLE.
- `enable` input 1: thread active; gates acceptance of `start` only.
- `start` input 1: request a new operation; sampled in IDLE only.
- `op` input 2: operation select. 00 = MUL, 01 = DIV, 10 = REM, 11 = illegal.
- `rs` input WIDTH: first operand (multiplicand or dividend).
- `rt` input WIDTH: second operand (multiplier or divisor).
- `result_ack` input 1: core has consumed the result; sampled in DONE only.
- `busy` output WIDTH-independent 1: high whenever the state is not IDLE.
- `result_valid` output 1: high exactly while the state is DONE.
- `result` output WIDTH: operation result; stable throughout DONE.

## Operation
- FSM states are IDLE, CALC and DONE.
- **IDLE → CALC:** taken when `start && enable`.
  - `op`, `rs` and `rt` are latched on that edge.
  - The bit counter is cleared to 0.
- **IDLE → DONE directly** (no CALC cycles) for these cases:
  - op = 11 (illegal): `result` = 0.
  - op = DIV with `rt` = 0: `result` = all ones.
  - op = REM with `rt` = 0: `result` = `rs`.
- **CALC:** processes one bit per cycle; the counter increments each cycle. After WIDTH CALC cycles the FSM goes to DONE.
- **DONE → IDLE:** taken on `result_ack`. DONE is held indefinitely while `result_ack` = 0.
- **MUL (shift-add):**
  - The accumulator starts at 0.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left by 1 and the multiplier right by 1.
  - `result` = accumulator[WIDTH-1:0]; the product is truncated mod 2^WIDTH.
- **DIV/REM (restoring, unsigned):**
  - The partial remainder R is WIDTH+1 bits and starts at 0. Q starts as the dividend.
  - Each cycle: shift {R,Q} left by 1. If R ≥ divisor, subtract the divisor from R and set Q[0] = 1.
  - DIV returns Q; REM returns R[WIDTH-1:0].
- All arithmetic is unsigned; there is no overflow flag.
- `start` is ignored outside IDLE and while `enable` = 0.
- `enable` falling during CALC or DONE has no effect.
- `rs`, `rt` and `op` changes after the accept edge have no effect.

## Timing
- Reset values: state IDLE; `busy` = 0, `result_valid` = 0, `result` = 0; all internal registers 0.
- A reset asserted in any state, including mid-CALC, takes effect on the next edge. The partial result is discarded.
- Cycle 0 is the edge that accepts `start`.
  - `busy` is high from cycle 1.
  - Normal ops: `result_valid` rises at cycle WIDTH+1 (cycle 9 for WIDTH = 8).
  - Early-complete cases: `result_valid` rises at cycle 1.
- When `result_ack` is sampled high in DONE:
  - `busy` and `result_valid` are 0 on the next cycle.
  - A `start` in that same ack cycle is ignored.
  - The earliest new accept is the cycle after IDLE is re-entered.
- `result` updates only on the entry to DONE, and is held through IDLE until the next DONE entry.

## Configuration
- `MULDIV_REM_EN` defined:
  - op 10 performs REM as above, including the REM-by-zero rule.
- `MULDIV_REM_EN` undefined:
  - op 10 is treated as illegal: `result` = 0, DONE at cycle 1.
  - The REM output path is not built.

## Structure
- Package `muldiv_pkg` holds:
  - the op encoding enum (OP_MUL, OP_DIV, OP_REM, OP_ILLEGAL);
  - the FSM state enum (S_IDLE, S_CALC, S_DONE);
  - the default width constant.
- Sub-module `div_step`: combinational single restoring-divide step.
  - Input {R,Q}, divisor; output next {R,Q}.
  - Instantiated once and used every CALC cycle.

## Test plan
- MUL: `rs` = 13, `rt` = 11 → `result` = 143 (8'h8F). `busy` high cycles 1–9; `result_valid` high at cycle 9; hold for 3 cycles without ack and check `result` stays stable.
- MUL wrap: `rs` = 20, `rt` = 20 → `result` = 144 (8'h90). DIV: `rs` = 200, `rt` = 7 → 28. REM: 200, 7 → 4. Each gives `result_valid` at cycle 9.
- Divide by zero: DIV 55/0 → 8'hFF with `result_valid` at cycle 1; REM 55/0 → 55 at cycle 1. op = 11 → 0 at cycle 1.
- Ignored inputs:
  - `start` with `enable` = 0 → `busy` stays 0.
  - `start` pulsed during CALC → no restart; result unchanged.
  - `rs`/`rt` changed at cycle 3 → the original result is still produced.
- Reset at cycle 4 of a DIV → next cycle `busy` = 0, `result_valid` = 0, `result` = 0. A fresh MUL 3×5 then returns 15 at cycle 9.
- Build without `MULDIV_REM_EN`: REM 200/7 → `result` = 0 at cycle 1. MUL and DIV results are unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and default width for muldiv_unit.
package muldiv_pkg;
    localparam int MULDIV_WIDTH = 8;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_REM, OP_ILLEGAL} op_t;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-divide step on {R,Q} against divisor.
module div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [2*WIDTH:0] rq,
    input  logic [WIDTH-1:0] divisor,
    output logic [2*WIDTH:0] rq_next
);
    logic [WIDTH+1:0] rw;
    logic [WIDTH:0]   diff;
    logic             ge;
    always_comb begin
        rw      = rq[2*WIDTH:WIDTH-1];
        ge      = rw >= {2'b00, divisor};
        diff    = rw[WIDTH:0] - {1'b0, divisor};
        rq_next = ge ? {diff, rq[WIDTH-2:0], 1'b1} : {rq[2*WIDTH-1:0], 1'b0};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide with start/ack handshake.
// Define MULDIV_REM_EN to build the REM operation; otherwise op 10 is illegal.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             result_ack,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state;
    op_t              op_q;
    logic [WIDTH:0]   r, r_mul, r_n;
    logic [WIDTH-1:0] q, b, q_n, b_n, calc_res, early_res;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH:0] rq_n;
    logic             early;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rq      ({r, q}),
        .divisor (b),
        .rq_next (rq_n)
    );
    // MUL reuses r as accumulator, q as multiplicand and b as multiplier
    always_comb begin
        r_mul = r + (b[0] ? {1'b0, q} : '0);
        r_n   = op_q == OP_MUL ? r_mul : rq_n[2*WIDTH:WIDTH];
        q_n   = op_q == OP_MUL ? q << 1 : rq_n[WIDTH-1:0];
        b_n   = op_q == OP_MUL ? b >> 1 : b;
`ifdef MULDIV_REM_EN
        calc_res  = op_q == OP_DIV ? q_n : r_n[WIDTH-1:0];
        early     = op == OP_ILLEGAL || (op != OP_MUL && rt == '0);
        early_res = op == OP_DIV ? '1 : op == OP_REM ? rs : '0;
`else
        calc_res  = op_q == OP_MUL ? r_n[WIDTH-1:0] : q_n;
        early     = op[1] || (op == OP_DIV && rt == '0);
        early_res = op == OP_DIV ? '1 : '0;
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            op_q   <= OP_MUL;
            r      <= '0;
            q      <= '0;
            b      <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: if (start && enable) begin
                    op_q  <= op_t'(op);
                    r     <= '0;
                    q     <= rs;
                    b     <= rt;
                    cnt   <= '0;
                    state <= early ? S_DONE : S_CALC;
                    if (early) result <= early_res;
                end
                S_CALC: begin
                    r   <= r_n;
                    q   <= q_n;
                    b   <= b_n;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state  <= S_DONE;
                        result <= calc_res;
                    end
                end
                S_DONE: if (result_ack) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
    assign busy         = state != S_IDLE;
    assign result_valid = state == S_DONE;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic       clk = 0, reset = 1, enable = 0, start = 0, result_ack = 0;
    logic [1:0] op = 0;
    logic [7:0] rs = 0, rt = 0;
    logic       busy, result_valid;
    logic [7:0] result;
    int         vectors = 0, miscompares = 0;

    muldiv_unit #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .op(op),
        .rs(rs), .rt(rt), .result_ack(result_ack), .busy(busy),
        .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input int a, input int d, output int res, output int lat);
        lat = 9;
        case (o)
            2'd0: res = (a * d) % 256;
            2'd1: if (d == 0) begin res = 255; lat = 1; end else res = a / d;
`ifdef MULDIV_REM_EN
            2'd2: if (d == 0) begin res = a; lat = 1; end else res = a % d;
`else
            2'd2: begin res = 0; lat = 1; end
`endif
            default: begin res = 0; lat = 1; end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] d,
                          input bit disturb, input int hold);
        int res, lat, cyc;
        model(o, int'(a), int'(d), res, lat);
        @(negedge clk);
        enable = 1; start = 1; op = o; rs = a; rt = d;
        @(posedge clk); #1;
        start = disturb;
        if (disturb) begin rs = ~a; rt = d + 8'd3; op = o ^ 2'd1; enable = 0; end
        cyc = 1;
        while (result_valid !== 1'b1 && cyc < 16) begin
            check("busy_calc", busy, 1);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, lat);
        check("result", result, res);
        check("busy_done", busy, 1);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", result_valid, 1);
            check("hold_result", result, res);
        end
        @(negedge clk);
        result_ack = 1; start = 1; enable = 1;
        @(posedge clk); #1;
        check("ack_busy", busy, 0);
        check("ack_valid", result_valid, 0);
        @(negedge clk);
        result_ack = 0; start = 0;
        @(posedge clk); #1;
        check("ack_start_ignored", busy, 0);
        check("idle_result_held", result, res);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_valid", result_valid, 0);
        check("reset_result", result, 0);
        @(negedge clk) reset = 0;

        run_op(2'd0, 8'd13, 8'd11, 0, 3);
        // abort a DIV at cycle 4: result must clear despite holding 143
        @(negedge clk);
        enable = 1; start = 1; op = 2'd1; rs = 8'd200; rt = 8'd7;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
        check("midreset_busy", busy, 0);
        check("midreset_valid", result_valid, 0);
        check("midreset_result", result, 0);
        @(negedge clk) reset = 0;
        run_op(2'd0, 8'd3, 8'd5, 0, 0);

        run_op(2'd0, 8'd20, 8'd20, 0, 0);
        run_op(2'd1, 8'd200, 8'd7, 0, 0);
        run_op(2'd2, 8'd200, 8'd7, 0, 0);
        run_op(2'd1, 8'd55, 8'd0, 0, 1);
        run_op(2'd2, 8'd55, 8'd0, 0, 1);
        run_op(2'd3, 8'd55, 8'd9, 0, 1);
        run_op(2'd0, 8'd13, 8'd11, 1, 0);
        run_op(2'd1, 8'd255, 8'd1, 1, 0);

        @(negedge clk);
        enable = 0; start = 1; op = 2'd0; rs = 8'd9; rt = 8'd9;
        repeat (3) begin
            @(posedge clk); #1;
            check("disabled_busy", busy, 0);
        end
        @(negedge clk);
        start = 0; enable = 1;

        for (int i = 0; i < 40; i++) begin
            logic [1:0] o;
            logic [7:0] a, d;
            o = 2'($urandom_range(0, 3));
            a = 8'($urandom);
            d = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            run_op(o, a, d, ($urandom_range(0, 3) == 0) && o == 2'd0, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
